// File: rtl/oddr_pkg.sv
// Shared types and PRBS7 helpers for the ODDR pattern generator.
// The LFSR is Fibonacci x^7 + x^6 + 1, shifting left with the new bit in bit 0.
package oddr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    CLK_FWD = 3'd1,
    TOGGLE  = 3'd2,
    PRBS7   = 3'd3,
    WALK    = 3'd4
  } mode_t;

  localparam int              PRBS_W    = 7;
  localparam logic [PRBS_W-1:0] PRBS_TAPS = 7'b110_0000;

  function automatic logic [PRBS_W-1:0] prbs_step(input logic [PRBS_W-1:0] s);
    return {s[PRBS_W-2:0], ^(s & PRBS_TAPS)};
  endfunction

  // All-zero is the LFSR lock-up state, so it is never used as a seed.
  function automatic logic [PRBS_W-1:0] prbs_seed(input logic [PRBS_W-1:0] base,
                                                  input int ch);
    logic [PRBS_W-1:0] s;
    s = base ^ PRBS_W'(ch);
    return (s == '0) ? 7'h01 : s;
  endfunction

endpackage

// File: rtl/prbs7_ddr.sv
// One channel of PRBS7, advanced two steps per word: first new bit for the
// rising edge, second for the falling edge.
module prbs7_ddr
  import oddr_pkg::*;
#(
  parameter logic [6:0] SEED = 7'h01
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic advance,
  output logic rise_bit,
  output logic fall_bit
);

  logic [PRBS_W-1:0] lfsr_reg;
  logic [PRBS_W-1:0] base;
  logic [PRBS_W-1:0] step1;
  logic [PRBS_W-1:0] step2;

  // On load the word is generated straight from the seed, so word 0 is ready
  // in the same cycle the burst is accepted.
  assign base     = load ? SEED : lfsr_reg;
  assign step1    = prbs_step(base);
  assign step2    = prbs_step(step1);
  assign rise_bit = step1[0];
  assign fall_bit = step2[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= SEED;
    end else if (load || advance) begin
      lfsr_reg <= step2;
    end
  end

endmodule

// File: rtl/oddr_pattern_gen.sv
// Burst pattern generator feeding external ODDR D1/D2 inputs.
// d_rise/d_fall always hold the word for the current cycle; k indexes that word.
module oddr_pattern_gen
  import oddr_pkg::*;
#(
  parameter int         NUM_CH    = 4,
  parameter int         BURST_W   = 16,
  parameter logic [6:0] PRBS_SEED = 7'h7F
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [BURST_W-1:0] burst_len,
  output logic               busy,
  output logic               done,
  output logic [NUM_CH-1:0]  d_rise,
  output logic [NUM_CH-1:0]  d_fall
);

  state_t              state_reg, state_next;
  mode_t               mode_reg, mode_next;
  logic [BURST_W-1:0]  len_reg, len_next;
  logic [31:0]         k_reg, k_next;
  logic [NUM_CH-1:0]   d_rise_reg, d_rise_next;
  logic [NUM_CH-1:0]   d_fall_reg, d_fall_next;

  logic                accept;
  logic                advance_word;
  logic                last_word;
  mode_t               word_mode;
  logic [31:0]         word_k;
  logic [31:0]         walk_idx;
  logic [NUM_CH-1:0]   pat_rise, pat_fall;
  logic [NUM_CH-1:0]   prbs_rise, prbs_fall;

  assign accept       = (state_reg == IDLE) && start && enable;
  assign last_word    = (len_reg != '0) && (k_reg == 32'(len_reg) - 32'd1);
  assign advance_word = (state_reg == RUN) && enable && !last_word;

  // The word being built is either word 0 of a new burst (fresh mode) or the
  // successor of the word currently on the outputs.
  assign word_mode = accept ? mode_t'(mode) : mode_reg;
  assign word_k    = accept ? 32'd0 : k_reg + 32'd1;
  assign walk_idx  = word_k % 32'(NUM_CH);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      prbs7_ddr #(
        .SEED(prbs_seed(PRBS_SEED, gi))
      ) u_prbs (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .advance  (advance_word),
        .rise_bit (prbs_rise[gi]),
        .fall_bit (prbs_fall[gi])
      );
    end
  endgenerate

  always_comb begin
    pat_rise = '0;
    pat_fall = '0;
    case (word_mode)
      CLK_FWD: pat_rise = '1;
      TOGGLE: begin
        pat_rise = {NUM_CH{word_k[0]}};
        pat_fall = {NUM_CH{word_k[0]}};
      end
      PRBS7: begin
        pat_rise = prbs_rise;
        pat_fall = prbs_fall;
      end
      WALK: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (walk_idx == 32'(c)) begin
            pat_rise[c] = 1'b1;
            pat_fall[c] = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign d_rise_next = (accept || advance_word) ? pat_rise : '0;
  assign d_fall_next = (accept || advance_word) ? pat_fall : '0;

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    len_next   = len_reg;
    k_next     = k_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
          mode_next  = mode_t'(mode);
          len_next   = burst_len;
          k_next     = 32'd0;
        end
      end
      RUN: begin
        // Loss of enable wins over completion: abort without a done pulse.
        if (!enable) begin
          state_next = IDLE;
        end else if (last_word) begin
          state_next = DONE;
        end else begin
          k_next = k_reg + 32'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      mode_reg   <= OFF;
      len_reg    <= '0;
      k_reg      <= 32'd0;
      d_rise_reg <= '0;
      d_fall_reg <= '0;
    end else begin
      state_reg  <= state_next;
      mode_reg   <= mode_next;
      len_reg    <= len_next;
      k_reg      <= k_next;
      d_rise_reg <= d_rise_next;
      d_fall_reg <= d_fall_next;
    end
  end

  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE);
  assign d_rise = d_rise_reg;
  assign d_fall = d_fall_reg;

endmodule

// File: doc/oddr_pattern_gen.md
ODDR_PATTERN_GEN -- requirements
Module: oddr_pattern_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of DDR output channels, legal range 1..32.
REQ-002 Parameter BURST_W, default 16: width of the burst length and word counter.
REQ-003 Parameter PRBS_SEED, default 7'h7F: base PRBS7 seed.
REQ-004 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port enable, input, 1: run permission; low aborts a run.
REQ-007 Port start, input, 1: single-cycle request to begin a burst.
REQ-008 Port mode, input, 3: pattern select, latched on an accepted start.
REQ-009 Port burst_len, input, BURST_W: number of words to emit; 0 = continuous; latched on an accepted start.
REQ-010 Port busy, output, 1: high in RUN and DONE.
REQ-011 Port done, output, 1: one-cycle pulse when a finite burst completes.
REQ-012 Port d_rise, output, NUM_CH: rising-edge data per channel, registered, for the ODDR D1 inputs.
REQ-013 Port d_fall, output, NUM_CH: falling-edge data per channel, registered, for the ODDR D2 inputs.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE -> RUN SHALL occur when start=1 and enable=1 in the same cycle; that cycle latches mode and burst_len.
REQ-016 start SHALL be ignored outside IDLE, and also when enable=0.
REQ-017 Word 0 SHALL appear on d_rise/d_fall in the first RUN cycle (one cycle after start); each further RUN cycle SHALL present the next word.
REQ-018 A 32-bit word counter k SHALL clear on start and increment once per RUN cycle.
REQ-019 A finite burst SHALL emit exactly burst_len words; the cycle after the last word SHALL be in DONE.
REQ-020 In DONE: done=1 and outputs=0 for exactly one cycle; the next state SHALL be IDLE.
REQ-021 When burst_len=0 the block SHALL stay in RUN until enable=0; k wraps silently.
REQ-022 enable=0 in RUN SHALL force IDLE on the next cycle with outputs=0 and no done pulse; this takes priority over burst completion in the same cycle.
REQ-023 In IDLE and DONE, d_rise and d_fall SHALL be all zeros.
REQ-024 Mode 0 (OFF): all zeros.
REQ-025 Mode 1 (CLK_FWD): d_rise=all ones, d_fall=all zeros, giving a forwarded clock.
REQ-026 Mode 2 (TOGGLE): d_rise=d_fall=replicated k[0], giving a square wave at half the clk rate.
REQ-027 Mode 3 (PRBS7): each channel runs an x^7+x^6+1 LFSR advanced two steps per RUN cycle; the first new bit goes to d_rise, the second to d_fall.
REQ-028 PRBS7 seeding: channel c is seeded on start with PRBS_SEED ^ c; a zero result SHALL be replaced by 7'h01.
REQ-029 Mode 4 (WALK): only channel (k mod NUM_CH) is high on both edges.
REQ-030 Modes 5-7 SHALL behave as OFF.
REQ-031 Changes to mode or burst_len during RUN SHALL have no effect until the next accepted start.

Reset
REQ-032 When rst=1, on the next edge: state=IDLE, busy=0, done=0, d_rise=0, d_fall=0, k=0, and all LFSRs=their seeds.
REQ-033 rst SHALL override enable and start in the same cycle; reset during RUN SHALL abort without a done pulse.

Structure
REQ-034 A package oddr_pkg SHALL hold the state enum (IDLE/RUN/DONE), the mode enum (OFF, CLK_FWD, TOGGLE, PRBS7, WALK) and the PRBS7 polynomial and width constants.
REQ-035 The per-channel two-step LFSR SHALL be one sub-module, prbs7_ddr, instantiated NUM_CH times by a generate loop.
REQ-036 No vendor ODDR primitive SHALL be instantiated in this block; the parent instantiates ODDRs on d_rise/d_fall.

Verification
REQ-037 Finite CLK_FWD burst: NUM_CH=4, mode=1, burst_len=5, start -> busy for 6 cycles, d_rise=4'hF for 5 cycles, done pulses once in cycle 6, then IDLE with outputs 0.
REQ-038 TOGGLE from continuous to abort: mode=2, burst_len=0, run 10 cycles then enable=0 -> words alternate 0/F starting with 0, next cycle IDLE, no done pulse.
REQ-039 PRBS7: mode=3, burst_len=127, PRBS_SEED=7'h7F -> each channel's 254-bit stream matches the reference model, and ch0 != ch1.
REQ-040 WALK wrap: NUM_CH=4, mode=4, burst_len=6 -> d_rise sequence 1, 2, 4, 8, 1, 2.
REQ-041 Ignored requests: start while busy, start with enable=0, and mode change mid-run -> no effect on the current burst, word count, or done timing.
REQ-042 Reset mid-run: rst=1 in RUN cycle 3 -> next cycle all outputs 0, busy=0, no done; a later start begins again from word 0.
